// File: rtl/rover_pkg.sv
// rover_pkg: shared state encoding, H-bridge patterns and LED frequency codes for the rover drive
package rover_pkg;

    typedef enum logic [1:0] {DRIVE, HALT, TURN, ADV} driveState_t;

    // Direction patterns ordered {fwd_l, bwd_l, fwd_r, bwd_r}
    localparam logic [3:0] PAT_STOP  = 4'b0000;
    localparam logic [3:0] PAT_FWD   = 4'b1010;
    localparam logic [3:0] PAT_PIVOT = 4'b1000;
    localparam logic [3:0] PAT_CCW   = 4'b0110;
    localparam logic [3:0] PAT_CW    = 4'b1001;
    localparam logic [3:0] PAT_DRIFT = 4'b0010;

    localparam logic [3:0] FREQ_B_DEF = 4'd9;
    localparam logic [3:0] FREQ_R_DEF = 4'd10;
    localparam logic [3:0] FREQ_G_DEF = 4'd11;

    // Lowest set request bit selects the recovery; callers guarantee at least one bit is set
    function automatic logic [1:0] lowestReq(input logic [2:0] req);
        return req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/speed_ramp.sv
// speed_ramp: steps a speed level toward its target on each tick, dropping to 0 at once when forced
module speed_ramp #(
    parameter int SPEED_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SPEED_W-1:0] target,
    input  logic               tick,
    input  logic               forceZero,
    output logic [SPEED_W-1:0] level
);

    // A forced stop or zero target clears at once; otherwise one level per tick, holding at target
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) level <= '0;
        else level <= (forceZero || target == '0) ? '0
                    : !tick ? level
                    : level < target ? level + 1'b1
                    : level > target ? level - 1'b1 : level;

endmodule

// File: rtl/rover_drive_sequencer.sv
// rover_drive_sequencer: manual drive, metal-detect halt with LED blink, timed recovery manoeuvres
module rover_drive_sequencer
    import rover_pkg::*;
#(
    parameter int         SPEED_W   = 2,
    parameter int         RAMP_CYC  = 1_000_000,
    parameter int         TURN_CYC0 = 175_000_000,
    parameter int         TURN_CYC1 = 175_000_000,
    parameter int         TURN_CYC2 = 175_000_000,
    parameter int         ADV_CYC   = 200_000_000,
    parameter int         TMR_W     = 33,
    parameter int         BLINK_W   = 25,
    parameter logic [3:0] FREQ_B    = FREQ_B_DEF,
    parameter logic [3:0] FREQ_R    = FREQ_R_DEF,
    parameter logic [3:0] FREQ_G    = FREQ_G_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               move,
    input  logic               direction,
    input  logic               rotate,
    input  logic               ind_sns_n,
    input  logic [2:0]         rec_req,
    input  logic [3:0]         freq_state,
    output logic               fwd_l,
    output logic               bwd_l,
    output logic               fwd_r,
    output logic               bwd_r,
    output logic [SPEED_W-1:0] speed_l,
    output logic [SPEED_W-1:0] speed_r,
    output logic               led_r,
    output logic               led_g,
    output logic               led_b,
    output logic               busy
);

    localparam int RAMP_CW = RAMP_CYC > 1 ? $clog2(RAMP_CYC) : 1;
    localparam logic [SPEED_W-1:0] MAX_LVL  = '1;
    localparam logic [SPEED_W-1:0] HALF_LVL = MAX_LVL >> 1;
    // Sensor stage resets high so a reset never looks like a metal hit
    localparam logic [7:0] SYNC_RST = 8'b0000_1000;

    logic [7:0] syncA, syncB;
    logic en, mv, dir, rot, indN;
    logic [2:0] req;
    driveState_t state, stateNext;
    logic [TMR_W-1:0] timer, timerNext, turnLoad;
    logic [1:0] recIdx, recIdxNext, recLow;
    logic metal, metalNext;
    logic [3:0] dirPat, wantPat, patNext;
    logic [SPEED_W-1:0] wantL, wantR;
    logic patChange, tick, wrap, halted;
    logic [RAMP_CW-1:0] rampCnt;
    logic [BLINK_W-1:0] blinkCnt;

    assign {en, mv, dir, rot, indN, req} = syncB;
    assign recLow   = lowestReq(req);
    assign turnLoad = recLow == 2'd0 ? TMR_W'(TURN_CYC0 - 1)
                    : recLow == 2'd1 ? TMR_W'(TURN_CYC1 - 1) : TMR_W'(TURN_CYC2 - 1);
    assign {fwd_l, bwd_l, fwd_r, bwd_r} = dirPat;
    assign busy = state == TURN || state == ADV;

    // Two-flop synchronisers on every asynchronous switch and sensor input
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            syncA <= SYNC_RST;
            syncB <= SYNC_RST;
        end else begin
            syncA <= {enable, move, direction, rotate, ind_sns_n, rec_req};
            syncB <= syncA;
        end

    // FSM, recovery timer, selected recovery and metal latch
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state  <= DRIVE;
            timer  <= '0;
            recIdx <= '0;
            metal  <= 1'b0;
        end else begin
            state  <= stateNext;
            timer  <= timerNext;
            recIdx <= recIdxNext;
            metal  <= metalNext;
        end

    // Next state: recovery requests win in DRIVE/HALT, everything freezes while disabled
    always_comb begin
        stateNext  = state;
        timerNext  = timer;
        recIdxNext = recIdx;
        metalNext  = metal | ~indN;
        if (en)
            case (state)
                DRIVE, HALT: begin
                    stateNext  = |req ? TURN : (state == DRIVE && metal) ? HALT : state;
                    timerNext  = |req ? turnLoad : timer;
                    recIdxNext = |req ? recLow : recIdx;
                end
                TURN: begin
                    stateNext = timer == '0 ? ADV : TURN;
                    timerNext = timer == '0 ? TMR_W'(ADV_CYC - 1) : timer - 1'b1;
                end
                ADV: begin
                    stateNext = timer == '0 ? DRIVE : ADV;
                    timerNext = timer == '0 ? timer : timer - 1'b1;
                    metalNext = timer == '0 ? 1'b0 : metalNext;
                end
                default: ;
            endcase
    end

    // Desired pattern and speed targets; a pattern change goes through one all-stop cycle
    always_comb begin
        wantPat = PAT_STOP;
        wantL   = '0;
        wantR   = '0;
        if (en)
            case (state)
                DRIVE: begin
                    wantPat = !mv ? PAT_STOP : dir ? (rot ? PAT_DRIFT : PAT_FWD) : (rot ? PAT_PIVOT : PAT_STOP);
                    wantL   = (mv && dir && !rot) ? MAX_LVL : (mv && !dir && rot) ? HALF_LVL : '0;
                    wantR   = (mv && dir && !rot) ? MAX_LVL : (mv && dir && rot) ? HALF_LVL : '0;
                end
                TURN: begin
                    wantPat = recIdx == 2'd0 ? PAT_PIVOT : recIdx == 2'd1 ? PAT_CCW : PAT_CW;
                    wantL   = MAX_LVL;
                    wantR   = MAX_LVL;
                end
                ADV: begin
                    wantPat = PAT_FWD;
                    wantL   = HALF_LVL;
                    wantR   = HALF_LVL;
                end
                default: ;
            endcase
        patNext   = (wantPat != dirPat && dirPat != PAT_STOP) ? PAT_STOP : wantPat;
        patChange = patNext != dirPat;
    end

    assign tick = rampCnt == RAMP_CW'(RAMP_CYC - 1);

    // Registered direction bits and a ramp prescaler that restarts on every pattern change
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            dirPat  <= PAT_STOP;
            rampCnt <= '0;
        end else begin
            dirPat  <= patNext;
            rampCnt <= (patChange || tick) ? '0 : rampCnt + 1'b1;
        end

    speed_ramp #(.SPEED_W(SPEED_W)) rampL (
        .clk(clk), .reset_n(reset_n), .target(wantL), .tick(tick), .forceZero(patChange), .level(speed_l)
    );

    speed_ramp #(.SPEED_W(SPEED_W)) rampR (
        .clk(clk), .reset_n(reset_n), .target(wantR), .tick(tick), .forceZero(patChange), .level(speed_r)
    );

    assign wrap   = blinkCnt == '1;
    assign halted = en && state == HALT;

    // Free-running blink counter; only the colour matching the frequency code blinks in HALT
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            blinkCnt <= '0;
            led_r    <= 1'b0;
            led_g    <= 1'b0;
            led_b    <= 1'b0;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
            led_r    <= (halted && freq_state == FREQ_R) ? led_r ^ wrap : 1'b0;
            led_g    <= (halted && freq_state == FREQ_G) ? led_g ^ wrap : 1'b0;
            led_b    <= (halted && freq_state == FREQ_B) ? led_b ^ wrap : 1'b0;
        end

endmodule

// File: tb/tb_rover_drive_sequencer.sv
// tb_rover_drive_sequencer: directed checks of drive, halt/blink, recovery, reset and enable freeze
module tb_rover_drive_sequencer;

    logic clk = 1'b0;
    logic reset_n, enable, move, direction, rotate, ind_sns_n;
    logic [2:0] rec_req;
    logic [3:0] freq_state;
    logic fwd_l, bwd_l, fwd_r, bwd_r, led_r, led_g, led_b, busy;
    logic [1:0] speed_l, speed_r;
    logic [3:0] pat;
    int passCnt = 0;
    int failCnt = 0;
    int total = 0;
    int guardViol = 0;
    int cwCnt;

    assign pat = {fwd_l, bwd_l, fwd_r, bwd_r};

    always #5 clk = ~clk;

    rover_drive_sequencer #(
        .SPEED_W(2), .RAMP_CYC(4), .TURN_CYC0(20), .TURN_CYC1(30), .TURN_CYC2(40),
        .ADV_CYC(50), .TMR_W(33), .BLINK_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .move(move), .direction(direction),
        .rotate(rotate), .ind_sns_n(ind_sns_n), .rec_req(rec_req), .freq_state(freq_state),
        .fwd_l(fwd_l), .bwd_l(bwd_l), .fwd_r(fwd_r), .bwd_r(bwd_r),
        .speed_l(speed_l), .speed_r(speed_r),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy)
    );

    // Shoot-through guard: a side's forward and reverse bits must never be on together
    always @(negedge clk)
        assert (!((fwd_l && bwd_l) || (fwd_r && bwd_r))) else guardViol++;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1; enable = 0; move = 0; direction = 0; rotate = 0;
        ind_sns_n = 1; rec_req = 3'b000; freq_state = 4'd0;
        #1 reset_n = 1'b0;
        step(3);
        chk("rst_pat", pat, 4'b0000);
        chk("rst_spd", {speed_l, speed_r}, 4'b0000);
        chk("rst_led", {led_r, led_g, led_b}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        step(3);

        // Straight forward: 3-cycle latency then soft start 0->1->2->3
        enable = 1; move = 1; direction = 1; rotate = 0;
        step(2); chk("fwd_latency", pat, 4'b0000);
        step(1); chk("fwd_pat", pat, 4'b1010); chk("fwd_spd0", speed_l, 2'd0);
        step(3); chk("fwd_spd0_hold", speed_l, 2'd0);
        step(1); chk("fwd_spd1", {speed_l, speed_r}, 4'b0101);
        step(4); chk("fwd_spd2", {speed_l, speed_r}, 4'b1010);
        step(4); chk("fwd_spd3", {speed_l, speed_r}, 4'b1111);
        step(8); chk("fwd_sat", {speed_l, speed_r}, 4'b1111);

        // Drift turn from full speed: one all-stop cycle, then 0010 with R ramping from 0
        rotate = 1;
        step(2); chk("drift_pre", pat, 4'b1010);
        step(1); chk("drift_gap_pat", pat, 4'b0000); chk("drift_gap_spd", {speed_l, speed_r}, 4'b0000);
        step(1); chk("drift_pat", pat, 4'b0010); chk("drift_r0", speed_r, 2'd0);
        step(3); chk("drift_r0_hold", speed_r, 2'd0);
        step(1); chk("drift_r1", {speed_l, speed_r}, 4'b0001);
        step(4); chk("drift_r_sat", {speed_l, speed_r}, 4'b0001);

        // Metal hit with red code: halt, then red blinks with a 16-cycle half period
        ind_sns_n = 0; freq_state = 4'd10;
        step(4); chk("halt_pre", pat, 4'b0010);
        step(1); chk("halt_pat", pat, 4'b0000); chk("halt_spd", {speed_l, speed_r}, 4'b0000);
        for (int i = 0; i < 40 && led_r !== 1'b1; i++) step(1);
        chk("led_r_rise", led_r, 1'b1);
        chk("led_gb_off", {led_g, led_b}, 2'b00);
        step(15); chk("led_r_hold", led_r, 1'b1);
        step(1); chk("led_r_toggle", led_r, 1'b0);
        step(16); chk("led_r_toggle2", led_r, 1'b1);
        freq_state = 4'd5;
        step(1); chk("led_unknown_off", {led_r, led_g, led_b}, 3'b000);

        // Recovery from HALT with rec_req=110: CCW wins over CW, 30 turn cycles then 50 advance
        ind_sns_n = 1;
        step(5); chk("halt_stays", {busy, pat}, 5'b00000);
        rec_req = 3'b110;
        step(1); rec_req = 3'b000;
        step(1); chk("rec_busy_lat", busy, 1'b0);
        step(1); chk("rec_busy", {busy, pat}, 5'b10000);
        step(1); chk("ccw_start", pat, 4'b0110);
        step(16); chk("ccw_spd", {speed_l, speed_r}, 4'b1111);
        step(13); chk("ccw_last", pat, 4'b0110);
        step(1); chk("ccw_to_adv_gap", pat, 4'b0000);
        step(1); chk("adv_pat", pat, 4'b1010);
        step(10); chk("adv_spd", {speed_l, speed_r}, 4'b0101);
        step(5); rec_req = 3'b001;
        step(1); rec_req = 3'b000;
        step(31); chk("adv_last", {busy, pat}, 5'b11010);
        step(1); chk("rec_done", busy, 1'b0);
        step(7); chk("latch_cleared", {busy, pat}, 5'b00010);

        // Pivot recovery aborted by asynchronous reset
        rec_req = 3'b001;
        step(1); rec_req = 3'b000;
        step(15); chk("pivot_run", {busy, pat, speed_l}, 7'b1100010);
        reset_n = 1'b0;
        #1;
        chk("abort_pat", pat, 4'b0000);
        chk("abort_spd", {speed_l, speed_r}, 4'b0000);
        chk("abort_busy", busy, 1'b0);
        step(1); reset_n = 1'b1;
        step(2); chk("post_rst_lat", pat, 4'b0000);
        step(1); chk("post_rst_drive", {busy, pat}, 5'b00010);

        // CW recovery with a 10-cycle enable drop mid-turn: turn still lasts 40 cycles in total
        move = 0;
        step(5); chk("idle", pat, 4'b0000);
        rec_req = 3'b100;
        step(1); rec_req = 3'b000;
        cwCnt = 0;
        for (int i = 1; i <= 140; i++) begin
            step(1);
            if (pat === 4'b1001) cwCnt++;
            if (i == 9) enable = 0;
            if (i == 14) chk("disabled_out", {busy, pat, speed_l, speed_r}, 9'b100000000);
            if (i == 19) enable = 1;
        end
        chk("cw_cycles", cwCnt, 40);
        chk("cw_done", {busy, pat}, 5'b00000);

        chk("guard", guardViol, 0);
        $display("%0d/%0d checks passed", passCnt, total);
        $finish;
    end

endmodule
